// File: rtl/multicycle_control.sv
// Main control FSM for a multi-cycle MIPS-subset datapath: sequences the shared
// ALU, register file, PC and one memory port, with wait states, trap and retire count.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_R:         state_d = S_REXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_IEXEC;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADDR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_REXEC:   state_d = S_RWB;
      S_RWB:     state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_IEXEC:   state_d = S_IWB;
      S_IWB:     state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_FETCH;
    endcase
  end

  // An instruction retires on the edge that returns the FSM to FETCH from a final state.
  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_IWB: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  assign illegal_d = illegal_q | (state_d == S_TRAP);
  assign cnt_d     = retire ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_IWB:   RegWrite = 1'b1;
      default: ;
    endcase
    // Reset aborts whatever is in flight: no write or request escapes this cycle.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
    end
  end

  assign illegal     = illegal_q;
  assign instr_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-state control words, wait states,
// trap behaviour, reset abort and retire-counter wrap (CNT_W = 4).
module tb_multicycle_control;
  localparam int CNT_W = 4;

  // Control word order: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
  // MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB[1:0],PCSource[1:0],ALUOp[1:0]
  localparam logic [15:0] C_FETCH_R = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [15:0] C_FETCH_W = 16'b0_0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [15:0] C_DECODE  = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [15:0] C_MEMADDR = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [15:0] C_MEMRD   = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_MEMWB   = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [15:0] C_MEMWR   = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_REXEC   = 16'b0_0_0_0_0_0_0_0_0_1_00_00_10;
  localparam logic [15:0] C_RWB     = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [15:0] C_BRANCH  = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [15:0] C_JUMP    = 16'b1_0_0_0_0_0_0_0_0_0_00_10_00;
  localparam logic [15:0] C_IEXEC   = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [15:0] C_IWB     = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [5:0]       opcode = 6'd0;
  logic             mem_ready = 1'b0;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]       ALUSrcB, PCSource, ALUOp;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;

  logic [15:0]      ctl;
  logic [5:0]       en;
  logic [CNT_W-1:0] exp_cnt = '0;
  int               vecs = 0;
  int               miss = 0;

  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp};
  assign en  = {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite};

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
    .illegal(illegal), .instr_count(instr_count), .state(state)
  );

  // Clock and global time bound
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; opcode = OP_R;
    @(posedge clk); #2;
    if (en !== 6'd0 || state !== 4'd0 || illegal !== 1'b0 || instr_count !== 4'd0) begin
      $display("FAIL reset_hold: en=%b state=%0d illegal=%b cnt=%0d, expected en=0 state=0 illegal=0 cnt=0",
               en, state, illegal, instr_count);
      miss++;
    end
    vecs++;
    rst = 1'b0; #1;
    if (ctl !== C_FETCH_R) begin
      $display("FAIL reset_release: ctl=%b expected %b", ctl, C_FETCH_R);
      miss++;
    end
    vecs++;
  endtask

  task automatic test_rtype();
    logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    logic [15:0] ct [4] = '{C_FETCH_R, C_DECODE, C_REXEC, C_RWB};
    opcode = OP_R;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      if (state !== st[i] || ctl !== ct[i]) begin
        $display("FAIL rtype[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b", i, state, ctl, st[i], ct[i]);
        miss++;
      end
      vecs++;
      @(posedge clk); #2;
    end
    exp_cnt = exp_cnt + 1'b1; #1;
    if (state !== 4'd0 || instr_count !== exp_cnt) begin
      $display("FAIL rtype_retire: state=%0d cnt=%0d, expected state=0 cnt=%0d", state, instr_count, exp_cnt);
      miss++;
    end
    vecs++;
  endtask

  task automatic test_lw_wait();
    logic [3:0]  st [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    logic [15:0] ct [7] = '{C_FETCH_R, C_DECODE, C_MEMADDR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB};
    logic        mr [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = OP_LW;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i]; #1;
      if (state !== st[i] || ctl !== ct[i]) begin
        $display("FAIL lw_wait[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b", i, state, ctl, st[i], ct[i]);
        miss++;
      end
      vecs++;
      @(posedge clk); #2;
    end
    exp_cnt = exp_cnt + 1'b1; #1;
    if (state !== 4'd0 || instr_count !== exp_cnt) begin
      $display("FAIL lw_retire: state=%0d cnt=%0d, expected state=0 cnt=%0d", state, instr_count, exp_cnt);
      miss++;
    end
    vecs++;
  endtask

  task automatic test_fetch_wait();
    logic [3:0]  st [8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    logic [15:0] ct [8] = '{C_FETCH_W, C_FETCH_W, C_FETCH_W, C_FETCH_R, C_DECODE, C_MEMADDR, C_MEMWR, C_MEMWR};
    logic        mr [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    opcode = OP_SW;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i]; #1;
      if (state !== st[i] || ctl !== ct[i]) begin
        $display("FAIL fetch_wait_sw[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b", i, state, ctl, st[i], ct[i]);
        miss++;
      end
      vecs++;
      @(posedge clk); #2;
    end
    exp_cnt = exp_cnt + 1'b1; #1;
    if (state !== 4'd0 || instr_count !== exp_cnt) begin
      $display("FAIL sw_retire: state=%0d cnt=%0d, expected state=0 cnt=%0d", state, instr_count, exp_cnt);
      miss++;
    end
    vecs++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  st [10] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd10, 4'd11};
    logic [15:0] ct [10] = '{C_FETCH_R, C_DECODE, C_BRANCH, C_FETCH_R, C_DECODE, C_JUMP,
                             C_FETCH_R, C_DECODE, C_IEXEC, C_IWB};
    logic [5:0]  op [10] = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_J, OP_J, OP_J,
                             OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI};
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'b1; opcode = op[i]; #1;
      if (state !== st[i] || ctl !== ct[i]) begin
        $display("FAIL b2b[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b", i, state, ctl, st[i], ct[i]);
        miss++;
      end
      vecs++;
      @(posedge clk); #2;
    end
    exp_cnt = exp_cnt + 3'd3; #1;
    if (state !== 4'd0 || instr_count !== exp_cnt) begin
      $display("FAIL b2b_retire: state=%0d cnt=%0d, expected state=0 cnt=%0d", state, instr_count, exp_cnt);
      miss++;
    end
    vecs++;
  endtask

  task automatic test_trap();
    opcode = 6'b111111;
    mem_ready = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    for (int i = 0; i < 12; i++) begin
      mem_ready = i[0]; #1;
      if (state !== 4'd12 || ctl !== 16'd0 || illegal !== 1'b1 || instr_count !== exp_cnt) begin
        $display("FAIL trap[%0d]: state=%0d ctl=%b illegal=%b cnt=%0d, expected state=12 ctl=0 illegal=1 cnt=%0d",
                 i, state, ctl, illegal, instr_count, exp_cnt);
        miss++;
      end
      vecs++;
      @(posedge clk); #2;
    end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0; exp_cnt = '0; #1;
    if (state !== 4'd0 || illegal !== 1'b0 || instr_count !== exp_cnt) begin
      $display("FAIL trap_clear: state=%0d illegal=%b cnt=%0d, expected state=0 illegal=0 cnt=0",
               state, illegal, instr_count);
      miss++;
    end
    vecs++;
  endtask

  task automatic test_reset_memwr();
    mem_ready = 1'b1; opcode = OP_J;
    repeat (3) begin @(posedge clk); #2; end
    exp_cnt = exp_cnt + 1'b1;
    opcode = OP_SW;
    repeat (3) begin @(posedge clk); #2; end
    rst = 1'b1; #1;
    if (state !== 4'd5 || en !== 6'd0) begin
      $display("FAIL memwr_rst_cycle: state=%0d en=%b, expected state=5 en=0", state, en);
      miss++;
    end
    vecs++;
    @(posedge clk); #2;
    rst = 1'b0; exp_cnt = '0; #1;
    if (state !== 4'd0 || instr_count !== exp_cnt) begin
      $display("FAIL memwr_rst_after: state=%0d cnt=%0d, expected state=0 cnt=0", state, instr_count);
      miss++;
    end
    vecs++;
  endtask

  task automatic test_wrap();
    mem_ready = 1'b1; opcode = OP_J;
    for (int k = 0; k < 16; k++) begin
      repeat (3) begin @(posedge clk); #2; end
      exp_cnt = exp_cnt + 1'b1; #1;
      if (instr_count !== exp_cnt || state !== 4'd0) begin
        $display("FAIL wrap[%0d]: cnt=%0d state=%0d, expected cnt=%0d state=0", k, instr_count, state, exp_cnt);
        miss++;
      end
      vecs++;
    end
    if (instr_count !== 4'd0) begin
      $display("FAIL wrap_zero: cnt=%0d expected 0", instr_count);
      miss++;
    end
    vecs++;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_fetch_wait();
    test_back_to_back();
    test_trap();
    test_reset_memwr();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle MIPS-subset datapath. It sequences one shared ALU, register file, PC and a single instruction/data memory port over several cycles per instruction. It drives `ALUOp` into the ALU control block, which combines it with `funct`. It also handles memory wait states, traps illegal opcodes and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `opcode`  input  6  `IR[31:26]`; valid from the DECODE state onward.
- `mem_ready`  input  1  memory completes the current access this cycle.
- `PCWrite`  output  1  unconditional PC load.
- `PCWriteCond`  output  1  PC load if ALU zero.
- `IorD`  output  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`  output  1  memory read request.
- `MemWrite`  output  1  memory write request.
- `IRWrite`  output  1  instruction register load.
- `MemtoReg`  output  1  register write data select: 1 = MDR.
- `RegDst`  output  1  destination select: 1 = rd, 0 = rt.
- `RegWrite`  output  1  register file write enable.
- `ALUSrcA`  output  1  ALU A select: 0 = PC, 1 = register A.
- `ALUSrcB`  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2.
- `PCSource`  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUOp`  output  2  00 = add (address/PC), 01 = compare-subtract (beq), 10 = decode `funct`.
- `illegal`  output  1  sticky trap flag.
- `instr_count`  output  `CNT_W`  retired-instruction counter.
- `state`  output  4  current state encoding, for debug.

## Operation
- Opcodes:
  - R-type `000000`
  - lw `100011`
  - sw `101011`
  - beq `000100`
  - addi `001000`
  - j `000010`
  - any other opcode is illegal.
- States and encodings:
  - FETCH = 0, DECODE = 1, MEMADDR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - REXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, IEXEC = 10, IWB = 11, TRAP = 12.
- Every output not listed for a state is 0.
- FETCH:
  - Asserts MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal `mem_ready` (combinational).
  - Stays in FETCH while `mem_ready`=0; moves to DECODE when it is 1.
- DECODE:
  - Asserts ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precomputed into ALUOut).
  - Next state: lw/sw → MEMADDR, R → REXEC, beq → BRANCH, j → JUMP, addi → IEXEC, other → TRAP.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Waits for `mem_ready`, then goes to FETCH.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH.
- TRAP:
  - `illegal`=1 and all enables are 0.
  - Remains in TRAP until `rst`.
- `instr_count`:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP or IWB.
  - Wraps modulo 2^`CNT_W`.
  - Never increments in or out of TRAP.

## Timing
- Outputs are Moore, decoded from the state register. The only exceptions are IRWrite and PCWrite in FETCH, which follow `mem_ready` in the same cycle.
- Reset:
  - While `rst`=1, every enable output is forced to 0. This covers PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite and RegWrite.
  - At the edge where `rst`=1: state ← FETCH, `illegal` ← 0, `instr_count` ← 0.
- Reset asserted mid-instruction (including during a memory wait) aborts it: no counter increment and no write enable in the reset cycle.
- Latency with zero wait states (`mem_ready` held at 1), counted from the FETCH cycle to the next FETCH:
  - lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
- Each extra cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_ready` outside FETCH, MEMRD and MEMWR is ignored.
- `opcode` is sampled only in DECODE and MEMADDR.

## Test plan
- Reset, then hold `mem_ready`=1 and feed R-type → state sequence 0,1,6,7,0. RegWrite=1 with RegDst=1 in RWB only. `instr_count`=1 after RWB.
- lw with `mem_ready` low for 2 cycles in MEMRD → MEMRD lasts 3 cycles with MemRead=1, IorD=1. MEMWB asserts RegWrite=1, MemtoReg=1. Total 7 cycles.
- FETCH with `mem_ready`=0 for 3 cycles → IRWrite=PCWrite=0 during the wait. Both are 1 in the 4th cycle, then DECODE.
- beq, j and addi back-to-back with zero waits:
  - beq: ALUOp=01 and PCWriteCond=1 in BRANCH.
  - j: PCSource=10 in JUMP.
  - addi: ALUOp=00 and ALUSrcB=10 in IEXEC.
  - `instr_count`=3 after the three instructions.
- Opcode `111111` → TRAP, `illegal`=1, all enables 0 for 10 or more cycles, counter frozen. `rst` → `illegal`=0, state=0.
- `rst` pulsed during MEMWR with `mem_ready`=1 → MemWrite=0 in that cycle. Next state FETCH, `instr_count`=0.
- Counter wrap with `CNT_W`=4: retire 16 instructions → `instr_count` returns to 0.
